// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the legal range of the operand width parameter.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int unsigned WIDTH_MIN = 2;
   localparam int unsigned WIDTH_MAX = 64;

   function automatic bit width_legal(input int unsigned w);
      return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
   endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// Combinational 1-bit full subtractor (x - y - br) built from two
// half-subtractor stages; the two stage borrows are ORed into the borrow-out.
module fs_cell (
   input  logic i_x,
   input  logic i_y,
   input  logic i_br,
   output logic o_d,
   output logic o_br
);

   logic w_d1;
   logic w_b1;
   logic w_b2;

   // first half subtractor: x - y
   assign w_d1 = i_x ^ i_y;
   assign w_b1 = ~i_x & i_y;

   // second half subtractor: (x - y) - br
   assign w_b2 = ~w_d1 & i_br;
   assign o_d  = w_d1 ^ i_br;
   assign o_br = w_b1 | w_b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock,
// LSB first, with a start/busy/done handshake.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow
// output ovf, registered together with diff on entry to DONE.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CW = $clog2(WIDTH);

   generate
      if (!width_legal(WIDTH)) begin : g_width_check
         $error("serial_subtractor: WIDTH out of range 2..64");
      end
   endgenerate

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_res_sh;
   logic [WIDTH-1:0] r_diff;
   logic [WIDTH-1:0] w_res_next;
   logic [CW-1:0]    r_cnt;
   logic             r_br;
   logic             r_bout;
   logic             w_d;
   logic             w_br;
   logic             w_last;
`ifdef SERIAL_SUB_OVF_EN
   logic             r_sa;
   logic             r_sb;
   logic             r_ovf;
`endif

   fs_cell u_fs_cell (
      .i_x  (r_a_sh[0]),
      .i_y  (r_b_sh[0]),
      .i_br (r_br),
      .o_d  (w_d),
      .o_br (w_br)
   );

   assign w_res_next = {w_d, r_res_sh[WIDTH-1:1]};
   assign w_last     = (r_cnt == CW'(WIDTH - 1));
   assign diff       = r_diff;
   assign bout       = r_bout;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf        = r_ovf;
`endif

   // state register; reset has priority over start
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // next-state and handshake outputs
   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (w_last) begin
               w_next = DONE;
            end
         end
         DONE: begin
            done   = 1'b1;
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // operand capture, serial shift datapath and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_res_sh <= '0;
         r_cnt    <= '0;
         r_br     <= 1'b0;
         r_diff   <= '0;
         r_bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         r_sa     <= 1'b0;
         r_sb     <= 1'b0;
         r_ovf    <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a_sh <= a;
                  r_b_sh <= b;
                  r_br   <= bin;
                  r_cnt  <= '0;
`ifdef SERIAL_SUB_OVF_EN
                  r_sa   <= a[WIDTH-1];
                  r_sb   <= b[WIDTH-1];
`endif
               end
            end
            SHIFT: begin
               r_res_sh <= w_res_next;
               r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
               r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
               r_br     <= w_br;
               r_cnt    <= r_cnt + CW'(1);
               if (w_last) begin
                  r_diff <= w_res_next;
                  r_bout <= w_br;
`ifdef SERIAL_SUB_OVF_EN
                  r_ovf  <= (r_sa != r_sb) && (w_res_next[WIDTH-1] != r_sa);
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: an 8-bit instance driven by
// directed and random operations through a scoreboard, plus an exhaustive
// sweep of a 2-bit instance. Build with SERIAL_SUB_OVF_EN to check ovf.
module tb_serial_subtractor;

   typedef struct packed {
      logic [7:0] d;
      logic       bo;
      logic       ov;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, bin;
   logic [7:0] a, b;
   logic       busy, done, bout;
   logic [7:0] diff;
   logic       start2, bin2;
   logic [1:0] a2, b2;
   logic       busy2, done2, bout2;
   logic [1:0] diff2;
`ifdef SERIAL_SUB_OVF_EN
   logic       ovf;
   logic       ovf2;
`endif

   int   total = 0;
   int   bad   = 0;
   int   cyc_cnt = 0;
   int   last_done = -1;
   exp_t sb[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   serial_subtractor #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   serial_subtractor #(.WIDTH(2)) dut2 (
      .clk   (clk),
      .rst   (rst),
      .start (start2),
      .a     (a2),
      .b     (b2),
      .bin   (bin2),
      .busy  (busy2),
      .done  (done2),
      .diff  (diff2),
      .bout  (bout2)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf   (ovf2)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic push_exp(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin);
      exp_t       e;
      logic [8:0] r;
      r    = {1'b0, ta} - {1'b0, tb_v} - {8'd0, tbin};
      e.d  = r[7:0];
      e.bo = r[8];
      e.ov = (ta[7] != tb_v[7]) && (r[7] != ta[7]);
      sb.push_back(e);
   endtask

   // Called at the negedge of the first SHIFT cycle: counts busy cycles,
   // checks the done pulse and compares against the scoreboard head.
   task automatic wait_result();
      int   cyc;
      exp_t e;
      cyc = 0;
      while (busy === 1'b1 && cyc < 20) begin
         cyc++;
         @(negedge clk);
      end
      check("busy_len", 64'(cyc), 64'd8);
      check("done_hi", {63'd0, done}, 64'd1);
      if (last_done >= 0) check("done_space", {63'd0, (cyc_cnt - last_done) >= 10}, 64'd1);
      last_done = cyc_cnt;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("diff", {56'd0, diff}, {56'd0, e.d});
         check("bout", {63'd0, bout}, {63'd0, e.bo});
`ifdef SERIAL_SUB_OVF_EN
         check("ovf", {63'd0, ovf}, {63'd0, e.ov});
`endif
      end else begin
         check("sb_nonempty", 64'd0, 64'd1);
      end
      @(negedge clk);
      check("done_pulse", {63'd0, done}, 64'd0);
   endtask

   // Called at a negedge while the DUT is idle.
   task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin);
      push_exp(ta, tb_v, tbin);
      a = ta; b = tb_v; bin = tbin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      wait_result();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       saw_done;
      logic [2:0] r2;
      int         cyc;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
      start2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_diff", {56'd0, diff}, 64'd0);
      check("rst_bout", {63'd0, bout}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // directed values and borrow/wrap boundaries
      do_op(8'd200, 8'd55, 1'b0);
      do_op(8'd10, 8'd20, 1'b0);
      do_op(8'd0, 8'd0, 1'b1);
      do_op(8'hFF, 8'hFF, 1'b1);
      do_op(8'hFF, 8'h00, 1'b0);
      do_op(8'h80, 8'h01, 1'b0);
      do_op(8'h7F, 8'hFF, 1'b0);
      do_op(8'h05, 8'h03, 1'b0);

      // start held high and operands changing during SHIFT
      push_exp(8'd200, 8'd55, 1'b0);
      a = 8'd200; b = 8'd55; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         a = 8'($urandom); b = 8'($urandom);
         @(negedge clk);
      end
      a = 8'($urandom); b = 8'($urandom);
      wait_result_held: begin
         // busy already observed for 7 cycles; the 8th is this one
         check("held_busy", {63'd0, busy}, 64'd1);
         @(negedge clk);
         check("held_done", {63'd0, done}, 64'd1);
         check("held_diff", {56'd0, diff}, 64'h91);
         check("held_bout", {63'd0, bout}, 64'd0);
         last_done = cyc_cnt;
      end
      void'(sb.pop_front());
      push_exp(8'd3, 8'd1, 1'b0);
      a = 8'd3; b = 8'd1; bin = 1'b0;
      @(negedge clk);
      check("held_idle_busy", {63'd0, busy}, 64'd0);
      check("held_idle_done", {63'd0, done}, 64'd0);
      @(negedge clk);
      start = 1'b0;
      wait_result();

      // reset on the 4th SHIFT cycle
      a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_done", {63'd0, done}, 64'd0);
      check("abort_diff", {56'd0, diff}, 64'd0);
      check("abort_bout", {63'd0, bout}, 64'd0);
      saw_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      end
      check("abort_quiet", {63'd0, saw_done}, 64'd0);
      last_done = -1;
      do_op(8'h55, 8'h0F, 1'b0);

      // rst and start together: reset wins
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      check("rst_start_busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      check("rst_start_busy2", {63'd0, busy}, 64'd0);
      last_done = -1;

      // random back-to-back operations
      for (int i = 0; i < 150; i++) begin
         do_op(8'($urandom), 8'($urandom), 1'($urandom));
      end

      // exhaustive 2-bit instance
      for (int i = 0; i < 32; i++) begin
         a2 = 2'(i); b2 = 2'(i >> 2); bin2 = 1'(i >> 4); start2 = 1'b1;
         r2 = {1'b0, a2} - {1'b0, b2} - {2'd0, bin2};
         @(negedge clk);
         start2 = 1'b0;
         cyc = 0;
         while (busy2 === 1'b1 && cyc < 10) begin
            cyc++;
            @(negedge clk);
         end
         check("w2_busy_len", 64'(cyc), 64'd2);
         check("w2_done", {63'd0, done2}, 64'd1);
         check("w2_result", {61'd0, bout2, diff2}, {61'd0, r2});
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
